// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line endpoint: deserialises 48-bit host commands on the oversampled SD clock,
// checks framing/CRC7, hands them to card logic and serialises the 48/136-bit response after Ncr.
module sd_card_cmd_responder #(
  parameter int NCR         = 2,
  parameter int RSP_TIMEOUT = 64
) (
  input  logic         wb_clk,
  input  logic         wb_rst_n,
  input  logic         sd_clk_pad,
  input  logic         sd_cmd_in,
  output logic         sd_cmd_out,
  output logic         sd_cmd_oe,
  output logic         cmd_valid,
  output logic         cmd_err,
  output logic [5:0]   cmd_index,
  output logic [31:0]  cmd_arg,
  output logic         rsp_ready,
  input  logic         rsp_valid,
  input  logic [1:0]   rsp_type,
  input  logic [127:0] rsp_data,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, RX, CHECK, WAIT_RSP, TX} state_t;
  state_t state, state_nxt;

  // Handshake: a response transfer happens on a wb_clk edge where rsp_valid && rsp_ready;
  // rsp_ready is high in WAIT_RSP until that transfer and low everywhere else.

  logic         clk_s1, clk_s2, clk_s3;
  logic         cmd_s1, cmd_s2;
  logic         rise, fall;
  logic [47:0]  rx_sr;
  logic [5:0]   bit_cnt;
  logic [6:0]   ncr_cnt;
  logic         rsp_taken;
  logic [135:0] tx_sr;
  logic [7:0]   tx_left;
  logic         frame_good, hs, timeout, tx_start;
  logic [39:0]  short_hdr;
  logic [6:0]   short_crc;
  logic [135:0] rsp_frame;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  function automatic logic [6:0] crc7_120(input logic [119:0] d);
    logic [6:0] c;
    c = 7'h00;
    for (int i = 119; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  // Clock and CMD go through matched synchronisers so CMD is aligned with the rise event.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      clk_s1 <= 1'b0;
      clk_s2 <= 1'b0;
      clk_s3 <= 1'b0;
      cmd_s1 <= 1'b1;
      cmd_s2 <= 1'b1;
    end else begin
      clk_s1 <= sd_clk_pad;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      cmd_s1 <= sd_cmd_in;
      cmd_s2 <= cmd_s1;
    end
  end

  assign rise = clk_s2 & ~clk_s3;
  assign fall = ~clk_s2 & clk_s3;

  assign frame_good = rx_sr[46] && rx_sr[0] && (crc7_40(rx_sr[47:8]) == rx_sr[7:1]);
  assign hs         = rsp_valid && rsp_ready;
  assign timeout    = (state == WAIT_RSP) && !rsp_taken && !hs && (ncr_cnt >= 7'(RSP_TIMEOUT));
  assign tx_start   = (state == WAIT_RSP) && rsp_taken && fall && (ncr_cnt >= 7'(NCR));

  assign short_hdr = {2'b00, rsp_data[37:0]};
  assign short_crc = (rsp_type == 2'd2) ? 7'h7F : crc7_40(short_hdr);
  assign rsp_frame = (rsp_type == 2'd3)
                   ? {2'b00, 6'h3F, rsp_data[127:8], crc7_120(rsp_data[127:8]), 1'b1}
                   : {short_hdr, short_crc, 1'b1, 88'd0};

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (rise && !cmd_s2) state_nxt = RX;
      RX:       if (rise && bit_cnt == 6'd47) state_nxt = CHECK;
      CHECK:    state_nxt = frame_good ? WAIT_RSP : IDLE;
      WAIT_RSP: begin
        if ((hs && rsp_type == 2'd0) || timeout) state_nxt = IDLE;
        else if (tx_start)                       state_nxt = TX;
      end
      TX:       if (fall && tx_left == 8'd0) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rsp_ready = (state == WAIT_RSP) && !rsp_taken;
    busy      = (state != IDLE);
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_sr      <= '0;
      bit_cnt    <= '0;
      ncr_cnt    <= '0;
      rsp_taken  <= 1'b0;
      tx_sr      <= '0;
      tx_left    <= '0;
      cmd_valid  <= 1'b0;
      cmd_err    <= 1'b0;
      cmd_index  <= '0;
      cmd_arg    <= '0;
      sd_cmd_out <= 1'b1;
      sd_cmd_oe  <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise && !cmd_s2) begin
            rx_sr   <= '0;
            bit_cnt <= 6'd1;
          end
        end
        RX: begin
          if (rise) begin
            rx_sr   <= {rx_sr[46:0], cmd_s2};
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        CHECK: begin
          ncr_cnt   <= '0;
          rsp_taken <= 1'b0;
          if (frame_good) begin
            cmd_index <= rx_sr[45:40];
            cmd_arg   <= rx_sr[39:8];
            cmd_valid <= 1'b1;
          end else begin
            cmd_err <= 1'b1;
          end
        end
        WAIT_RSP: begin
          if (rise && ncr_cnt != 7'h7F) ncr_cnt <= ncr_cnt + 7'd1;
          if (hs) begin
            rsp_taken <= 1'b1;
            tx_sr     <= rsp_frame;
            tx_left   <= (rsp_type == 2'd3) ? 8'd135 : 8'd47;
          end
          if (timeout) cmd_err <= 1'b1;
          // The start bit is launched here; tx_left then counts the bits still to send.
          if (tx_start) begin
            sd_cmd_out <= tx_sr[135];
            sd_cmd_oe  <= 1'b1;
            tx_sr      <= {tx_sr[134:0], 1'b0};
          end
        end
        TX: begin
          if (fall) begin
            if (tx_left == 8'd0) begin
              sd_cmd_oe  <= 1'b0;
              sd_cmd_out <= 1'b1;
            end else begin
              sd_cmd_out <= tx_sr[135];
              tx_sr      <= {tx_sr[134:0], 1'b0};
              tx_left    <= tx_left - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Bench for sd_card_cmd_responder: acts as SD host (drives CMD frames, decodes the CMD response
// on SD_CLK rising edges) and as card logic (offers responses), checked against a frame-level model.
module tb_sd_card_cmd_responder;

  localparam int NCR         = 2;
  localparam int RSP_TIMEOUT = 64;

  logic         wb_clk = 1'b0;
  logic         wb_rst_n = 1'b0;
  logic         sd_clk_pad = 1'b0;
  logic         sd_cmd_in = 1'b1;
  logic         sd_cmd_out, sd_cmd_oe, cmd_valid, cmd_err, rsp_ready, busy;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic         rsp_valid = 1'b0;
  logic [1:0]   rsp_type = 2'd0;
  logic [127:0] rsp_data = '0;

  sd_card_cmd_responder #(.NCR(NCR), .RSP_TIMEOUT(RSP_TIMEOUT)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .sd_clk_pad(sd_clk_pad), .sd_cmd_in(sd_cmd_in),
    .sd_cmd_out(sd_cmd_out), .sd_cmd_oe(sd_cmd_oe), .cmd_valid(cmd_valid), .cmd_err(cmd_err),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .rsp_ready(rsp_ready), .rsp_valid(rsp_valid),
    .rsp_type(rsp_type), .rsp_data(rsp_data), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  int half = 4;
  int sd_div = 0;
  always #5 wb_clk = ~wb_clk;
  always @(negedge wb_clk) begin
    sd_div++;
    if (sd_div >= half) begin
      sd_div = 0;
      sd_clk_pad = ~sd_clk_pad;
    end
  end

  // ---------------- bookkeeping ----------------
  int chk = 0, fail = 0;
  int rise_cnt = 0, end_rise = 0;
  int nvalid = 0, nerr = 0, err_rise = 0;
  logic [5:0]  last_idx = '0;
  logic [31:0] last_arg = '0;

  logic [135:0] exp_q[$];
  int           exp_len_q[$];
  int           exp_start_q[$];

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    chk++;
    if (act !== exp) begin
      fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // CRC7 as the remainder of d(x)*x^7 divided by x^7+x^3+1; leading zeros do not change it.
  function automatic logic [6:0] crc7_model(input logic [119:0] d);
    logic [126:0] r;
    r = {d, 7'b0};
    for (int i = 126; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_model(120'({2'b01, idx, arg})), 1'b1};
  endfunction

  function automatic logic [135:0] rsp_model(input logic [1:0] t, input logic [127:0] d);
    logic [39:0] h;
    h = {2'b00, d[37:0]};
    if (t == 2'd3) return {2'b00, 6'h3F, d[127:8], crc7_model(d[127:8]), 1'b1};
    return 136'({h, (t == 2'd2) ? 7'h7F : crc7_model(120'(h)), 1'b1});
  endfunction

  // ---------------- pulse counters ----------------
  always @(negedge wb_clk) begin
    if (cmd_valid === 1'b1) nvalid++;
    if (cmd_err === 1'b1) begin
      nerr++;
      err_rise = rise_cnt;
    end
  end

  // ---------------- host receiver / compare process ----------------
  logic [135:0] cap, cap_exp;
  int cap_n = 0, cap_len = 0;
  bit capturing = 1'b0, idle_chk = 1'b0;

  always @(posedge sd_clk_pad) begin
    rise_cnt++;
    if (!wb_rst_n) begin
      capturing = 1'b0;
      idle_chk  = 1'b0;
      exp_q.delete();
      exp_len_q.delete();
      exp_start_q.delete();
    end else if (idle_chk) begin
      check("oe_after_end_bit", 136'(sd_cmd_oe), 136'd0);
      idle_chk = 1'b0;
    end else if (capturing) begin
      check("oe_during_tx", 136'(sd_cmd_oe), 136'd1);
      cap = {cap[134:0], sd_cmd_out};
      cap_n++;
      if (cap_n == cap_len) begin
        check("rsp_frame", cap, cap_exp);
        capturing = 1'b0;
        idle_chk  = 1'b1;
      end
    end else if (sd_cmd_oe === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cmd_drive", 136'(sd_cmd_oe), 136'd0);
      end else begin
        cap_exp = exp_q.pop_front();
        cap_len = exp_len_q.pop_front();
        check("rsp_start_rise", 136'(rise_cnt), 136'(exp_start_q.pop_front()));
        check("rsp_start_bit", 136'(sd_cmd_out), 136'd0);
        cap       = 136'(sd_cmd_out);
        cap_n     = 1;
        capturing = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge sd_clk_pad);
      sd_cmd_in = f[i];
    end
    end_rise = rise_cnt + 1;
    @(negedge sd_clk_pad);
    sd_cmd_in = 1'b1;
  endtask

  // respond: 0 = never answer (timeout), 1 = answer after 'delay' SD rises; abort_tx resets mid-TX.
  task automatic do_cmd(input logic [47:0] f, input bit respond, input logic [1:0] typ,
                        input logic [127:0] data, input int delay, input bit abort_tx);
    int v0, e0, to, st;
    bit good;
    good = (f == cmd_frame(f[45:40], f[39:8]));
    v0 = nvalid;
    e0 = nerr;
    send_frame(f);
    to = 0;
    while (nvalid == v0 && nerr == e0 && to < 64) begin
      @(negedge wb_clk);
      to++;
    end
    repeat (3) @(negedge wb_clk);
    check("cmd_valid_pulses", 136'(nvalid - v0), 136'(good));
    check("cmd_err_pulses", 136'(nerr - e0), 136'(!good));
    if (good) begin
      last_idx = f[45:40];
      last_arg = f[39:8];
    end
    check("cmd_index", 136'(cmd_index), 136'(last_idx));
    check("cmd_arg", 136'(cmd_arg), 136'(last_arg));
    check("busy_after_frame", 136'(busy), 136'(good));
    if (!good) return;
    check("rsp_ready_in_wait", 136'(rsp_ready), 136'd1);
    if (!respond) begin
      to = 0;
      while (nerr == e0 && to < 2000) begin
        @(negedge wb_clk);
        to++;
      end
      check("timeout_err_pulses", 136'(nerr - e0), 136'd1);
      check("timeout_rise", 136'(err_rise), 136'(end_rise + RSP_TIMEOUT));
      repeat (2) @(negedge wb_clk);
      check("busy_after_timeout", 136'(busy), 136'd0);
      return;
    end
    repeat (delay) @(posedge sd_clk_pad);
    @(negedge wb_clk);
    check("busy_before_handshake", 136'(busy), 136'd1);
    if (typ != 2'd0) begin
      st = end_rise + NCR + 1;
      if (rise_cnt + 1 > st) st = rise_cnt + 1;
      exp_q.push_back(rsp_model(typ, data));
      exp_len_q.push_back((typ == 2'd3) ? 136 : 48);
      exp_start_q.push_back(st);
    end
    rsp_valid = 1'b1;
    rsp_type  = typ;
    rsp_data  = data;
    to = 0;
    while (rsp_ready !== 1'b1 && to < 100) begin
      @(negedge wb_clk);
      to++;
    end
    check("rsp_ready_at_offer", 136'(rsp_ready), 136'd1);
    @(negedge wb_clk);
    rsp_valid = 1'b0;
    rsp_type  = 2'($urandom);
    rsp_data  = {$urandom, $urandom, $urandom, $urandom};
    check("rsp_ready_dropped", 136'(rsp_ready), 136'd0);
    if (abort_tx) begin
      to = 0;
      while (!(capturing && cap_n >= 20) && to < 5000) begin
        @(negedge wb_clk);
        to++;
      end
      check("reached_mid_tx", 136'(sd_cmd_oe), 136'd1);
      #2 wb_rst_n = 1'b0;
      #1;
      check("oe_async_reset", 136'(sd_cmd_oe), 136'd0);
      check("out_async_reset", 136'(sd_cmd_out), 136'd1);
      check("busy_async_reset", 136'(busy), 136'd0);
      last_idx = '0;
      last_arg = '0;
      repeat (3) @(posedge sd_clk_pad);
      @(negedge wb_clk);
      wb_rst_n = 1'b1;
      return;
    end
    to = 0;
    while (busy !== 1'b0 && to < 3000) begin
      @(negedge wb_clk);
      to++;
    end
    check("busy_after_rsp", 136'(busy), 136'd0);
    repeat (2) @(posedge sd_clk_pad);
    check("rsp_all_seen", 136'(exp_q.size()), 136'd0);
    check("oe_idle", 136'(sd_cmd_oe), 136'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1500000;
    fail++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", chk, fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] cid;
    repeat (3) @(negedge wb_clk);
    check("rst_oe", 136'(sd_cmd_oe), 136'd0);
    check("rst_out", 136'(sd_cmd_out), 136'd1);
    check("rst_valid", 136'(cmd_valid), 136'd0);
    check("rst_err", 136'(cmd_err), 136'd0);
    check("rst_index", 136'(cmd_index), 136'd0);
    check("rst_arg", 136'(cmd_arg), 136'd0);
    check("rst_ready", 136'(rsp_ready), 136'd0);
    check("rst_busy", 136'(busy), 136'd0);
    wb_rst_n = 1'b1;

    check("pin_crc_cmd0", 136'(crc7_model(120'(40'h40_0000_0000))), 136'h4A);
    check("pin_frame_cmd0", 136'(cmd_frame(6'd0, 32'd0)), 136'h40_0000_0000_95);
    check("pin_frame_cmd8", 136'(cmd_frame(6'd8, 32'h1AA)), 136'h48_0000_01AA_87);
    check("pin_r7", rsp_model(2'd1, 128'({6'd8, 32'h0000_01AA})), 136'h08_0000_01AA_13);
    check("pin_r3", rsp_model(2'd2, 128'({6'h3F, 32'h80FF_8000})), 136'h3F_80FF_8000_FF);

    repeat (4) @(posedge sd_clk_pad);
    do_cmd(48'h40_0000_0000_95, 1'b1, 2'd0, '0, 1, 1'b0);
    do_cmd(48'h40_0000_0000_97, 1'b1, 2'd0, '0, 1, 1'b0);
    do_cmd(48'h48_0000_01AA_87, 1'b1, 2'd1, 128'({6'd8, 32'h0000_01AA}), 1, 1'b0);
    do_cmd(48'h48_0000_01AA_87, 1'b1, 2'd1, 128'({6'd8, 32'h0000_01AA}), 10, 1'b0);
    do_cmd(48'h48_0000_01AA_87, 1'b0, 2'd0, '0, 1, 1'b0);
    cid = 128'h0353_4453_4431_3038_8012_3456_7801_2345;
    do_cmd(cmd_frame(6'd2, 32'd0), 1'b1, 2'd3, cid, 2, 1'b0);
    do_cmd(cmd_frame(6'd41, 32'h40FF_8000), 1'b1, 2'd2, 128'({6'h3F, 32'h80FF_8000}), 1, 1'b0);
    do_cmd(48'h48_0000_01AA_87, 1'b1, 2'd3, cid, 1, 1'b1);
    repeat (2) @(posedge sd_clk_pad);
    do_cmd(48'h40_0000_0000_95, 1'b1, 2'd1, 128'({6'd0, 32'h0000_0900}), 3, 1'b0);

    for (int n = 0; n < 20; n++) begin
      logic [47:0] f;
      logic [127:0] d;
      int pos;
      half = $urandom_range(4, 6);
      repeat (2) @(posedge sd_clk_pad);
      f = cmd_frame(6'($urandom), $urandom);
      if ($urandom_range(0, 4) == 0) begin
        pos = $urandom_range(0, 46);
        f[pos] = ~f[pos];
      end
      d = {$urandom, $urandom, $urandom, $urandom};
      do_cmd(f, $urandom_range(0, 9) != 0, 2'($urandom), d, $urandom_range(1, 12), 1'b0);
    end

    repeat (4) @(posedge sd_clk_pad);
    $display("TB_RESULT checks=%0d failures=%0d", chk, fail);
    $finish;
  end

endmodule

// File: doc/sd_card_cmd_responder.md
Name: sd_card_cmd_responder

Overview:
- Card-side endpoint of the SD CMD line, used as an on-chip SD card model for loopback and bring-up of the SD host controller.
- Oversamples the forwarded SD_CLK pin on a single system clock and deserialises 48-bit host commands, checking their framing and CRC7.
- Hands the command index and argument to local card logic, then serialises R1/R3/R7-style 48-bit or R2 136-bit responses back onto CMD with correct Ncr spacing.

Parameters:
- NCR, 2, SD rising edges between the command end bit and the response start bit; legal range 2..63.
- RSP_TIMEOUT, 64, SD rising edges after the command end bit with no accepted response before WAIT_RSP abandons and returns to IDLE.

Ports:
- wb_clk  input  1  system clock; must be at least 4x the SD_CLK frequency.
- wb_rst_n  input  1  asynchronous active-low reset.
- sd_clk_pad  input  1  SD_CLK pin; asynchronous to wb_clk.
- sd_cmd_in  input  1  CMD pin input value.
- sd_cmd_out  output  1  CMD value driven by the card.
- sd_cmd_oe  output  1  CMD output enable.
- cmd_valid  output  1  one-cycle pulse; a good command frame was received.
- cmd_err  output  1  one-cycle pulse; a frame failed its checks.
- cmd_index  output  6  index of the last good command.
- cmd_arg  output  32  argument of the last good command.
- rsp_ready  output  1  high in WAIT_RSP.
- rsp_valid  input  1  response offered by the card logic.
- rsp_type  input  2  response format: 0 none, 1 short+CRC, 2 short with CRC field all ones (R3), 3 long (R2).
- rsp_data  input  128  short format: [37:0] = {index, payload}; long format: [127:1] = CID/CSD bits.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: sd_cmd_oe=0, sd_cmd_out=1, cmd_valid=0, cmd_err=0, cmd_index=0, cmd_arg=0, rsp_ready=0, busy=0; FSM in IDLE.
- Reset is asynchronous: asserting wb_rst_n mid-transfer drops sd_cmd_oe in the same instant.
- Input synchronisation:
  - sd_clk_pad and sd_cmd_in pass through matched 2-FF synchronisers.
  - A third clk stage gives the edge events: rise = s2&~s3, fall = ~s2&s3.
  - CMD is sampled from the synchronised CMD stage on rise events only.
- sd_cmd_out and sd_cmd_oe change only on the cycle after a fall event.
- CRC7:
  - Polynomial x^7+x^3+1, initial value 0, shifted MSB first.
  - For commands and short responses it covers the 40 bits from the start bit through the end of the argument/payload.
- FSM states:
  - IDLE: on a rise event with sampled CMD=0, go to RX and load the bit counter to 1.
  - RX: shift 47 further bits in on rise events, then go to CHECK.
  - CHECK (1 clk):
    - Good frame: transmission bit=1, computed CRC equals the received CRC, end bit=1.
    - Good: load cmd_index and cmd_arg, pulse cmd_valid, go to WAIT_RSP, clear the Ncr counter.
    - Otherwise: pulse cmd_err and return to IDLE.
  - WAIT_RSP:
    - rsp_ready=1; the Ncr counter increments on each rise event.
    - Handshake: rsp_valid&rsp_ready captures rsp_type/rsp_data and drops rsp_ready.
    - rsp_type=0 at handshake: return to IDLE without driving CMD.
    - Otherwise go to TX at the first fall event for which the counter is >= NCR; a late response starts at the next fall event after acceptance.
    - If the counter reaches RSP_TIMEOUT with no handshake: pulse cmd_err and go to IDLE.
  - TX (oe=1): one bit per fall event, MSB first.
    - Short response (48 bits): 0, 0, rsp_data[37:0], CRC7 (or 7'h7F for type 2), 1.
    - Long response (136 bits): 0, 0, 6'b111111, rsp_data[127:8], CRC7 over rsp_data[127:8], 1. rsp_data[7:1] is ignored.
    - At the fall event after the end bit: oe=0, out=1, go to IDLE.
- Arbitration: CMD input is ignored outside IDLE and RX, so the card's own transmission never starts a receive.
- Same-cycle events: a rise and a fall event cannot coincide because of the 4x clock ratio; the bench enforces that ratio.

Test Plan:
- Frame 48'h40_0000_0000_95 (CMD0) at SD_CLK = wb_clk/8 -> one cmd_valid pulse, cmd_index=0, cmd_arg=0, busy high from start bit to handshake.
- Same frame with CRC byte 8'h97 -> cmd_err pulse, no cmd_valid, FSM back in IDLE, sd_cmd_oe never asserted.
- Frame 48'h48_0000_01AA_87 (CMD8), rsp_type=1, rsp_data[37:0]={6'd8,32'h000001AA} offered immediately -> CMD carries 48'h08_0000_01AA_13. Start bit is launched at the fall event after the 2nd rise following the end bit (NCR=2).
- CMD8 frame, response offered 10 SD clocks late -> start bit launched at the first fall event after the handshake. A second run with no response -> cmd_err after 64 rise events, FSM in IDLE.
- rsp_type=3 with a known CID -> 136 bits, header 8'h3F, embedded CRC matches the software model. rsp_type=0 -> no CMD activity.
- wb_rst_n pulsed low mid-TX -> sd_cmd_oe=0 immediately. After release, a fresh CMD0 frame decodes correctly.
